// File: rtl/arcade_input_mapper_if.sv
// Player-input bus between the hps_io side and the arcade core.
//   ps2_key     : hps_io key event ([10] toggle, [9] pressed, [8] extended, [7:0] scancode)
//   joy         : 16 bits per player ([0] right, [1] left, [2] down, [3] up,
//                 [4+b] button b, [4+BUTTONS] start, [5+BUTTONS] coin)
//   rotate      : 0 none, 1 clockwise, 2 counter-clockwise, 3 same as 0
//   autofire_en : per-player autofire enable on button 0
//   player_out  : (6+BUTTONS) bits per player, LSB first:
//                 up, down, left, right, btn[0..BUTTONS-1], start, coin
// master drives the inputs and reads player_out; slave is the mapper.
interface arcade_input_mapper_if #(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 3
);
    logic [10:0]                    ps2_key;
    logic [16*PLAYERS-1:0]          joy;
    logic [1:0]                     rotate;
    logic [PLAYERS-1:0]             autofire_en;
    logic [(6+BUTTONS)*PLAYERS-1:0] player_out;

    modport master (
        output ps2_key,
        output joy,
        output rotate,
        output autofire_en,
        input  player_out
    );

    modport slave (
        input  ps2_key,
        input  joy,
        input  rotate,
        input  autofire_en,
        output player_out
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Arcade player-input front end: PS/2 key decode for players 1-2, joystick
// merge, screen-orientation remap of directions, coin pulse stretching and
// per-player autofire on button 0. All outputs are registered.
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset
//   bus     : arcade_input_mapper_if slave (ps2_key, joy, rotate,
//             autofire_en in; player_out out)
module arcade_input_mapper #(
    parameter int          PLAYERS      = 2,
    parameter int          BUTTONS      = 3,
    parameter logic [15:0] COIN_HOLD    = 16'd50000,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    arcade_input_mapper_if.slave  bus
);
    localparam int W  = 6 + BUTTONS;
    // Keyboard state per player: up, down, left, right, btn0..2, start, coin
    localparam int KW = 9;

    logic                       primed_q, primed_d;
    logic                       tog_q, tog_d;
    logic [1:0][KW-1:0]         key_q, key_d;
    logic [PLAYERS-1:0]         coin_prev_q, coin_prev_d;
    logic [PLAYERS-1:0][15:0]   coin_cnt_q, coin_cnt_d;
    logic [19:0]                div_q, div_d;
    logic                       phase_q, phase_d;
    logic [W*PLAYERS-1:0]       out_q, out_d;

    logic [5:0]                 key_dec;
    logic                       key_event;
    logic [PLAYERS-1:0][KW-1:0] kb;
    logic [PLAYERS-1:0][W-1:0]  mrg;

    // Scancode lookup: {hit, player, key-state index}. Arrows match with or
    // without the extended prefix; every other key requires it clear.
    function automatic logic [5:0] decode_key(input logic ext, input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        case (code)
            8'h75:   r = {1'b1, 1'b0, 4'd0};
            8'h72:   r = {1'b1, 1'b0, 4'd1};
            8'h6B:   r = {1'b1, 1'b0, 4'd2};
            8'h74:   r = {1'b1, 1'b0, 4'd3};
            default: begin
                if (!ext) begin
                    case (code)
                        8'h14, 8'h29: r = {1'b1, 1'b0, 4'd4};
                        8'h11:        r = {1'b1, 1'b0, 4'd5};
                        8'h12:        r = {1'b1, 1'b0, 4'd6};
                        8'h16, 8'h05: r = {1'b1, 1'b0, 4'd7};
                        8'h2E:        r = {1'b1, 1'b0, 4'd8};
                        8'h2D:        r = {1'b1, 1'b1, 4'd0};
                        8'h2B:        r = {1'b1, 1'b1, 4'd1};
                        8'h23:        r = {1'b1, 1'b1, 4'd2};
                        8'h34:        r = {1'b1, 1'b1, 4'd3};
                        8'h1C:        r = {1'b1, 1'b1, 4'd4};
                        8'h1B:        r = {1'b1, 1'b1, 4'd5};
                        8'h15:        r = {1'b1, 1'b1, 4'd6};
                        8'h1E, 8'h06: r = {1'b1, 1'b1, 4'd7};
                        8'h36:        r = {1'b1, 1'b1, 4'd8};
                        default:      r = 6'd0;
                    endcase
                end else begin
                    r = 6'd0;
                end
            end
        endcase
        return r;
    endfunction

    // Key event detection; the first cycle after reset only primes the toggle copy.
    always_comb begin
        tog_d     = bus.ps2_key[10];
        primed_d  = 1'b1;
        key_d     = key_q;
        key_dec   = decode_key(bus.ps2_key[8], bus.ps2_key[7:0]);
        key_event = primed_q && (bus.ps2_key[10] != tog_q);
        if (key_event && key_dec[5]) begin
            key_d[key_dec[4]][key_dec[3:0]] = bus.ps2_key[9];
        end else begin
            key_d = key_q;
        end
    end

    // Merge keyboard and joystick per player; players 3-4 have no keyboard map.
    always_comb begin
        kb  = '0;
        mrg = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            kb[p]     = (p < 2) ? key_q[p % 2] : {KW{1'b0}};
            mrg[p][0] = bus.joy[16*p+3] | kb[p][0];
            mrg[p][1] = bus.joy[16*p+2] | kb[p][1];
            mrg[p][2] = bus.joy[16*p+1] | kb[p][2];
            mrg[p][3] = bus.joy[16*p+0] | kb[p][3];
            for (int b = 0; b < BUTTONS; b++) begin
                // Keyboard maps only btn0..2; a fourth button is joystick-only.
                mrg[p][4+b] = bus.joy[16*p+4+b] | ((b < 3) ? kb[p][4+(b%3)] : 1'b0);
            end
            mrg[p][4+BUTTONS] = bus.joy[16*p+4+BUTTONS] | kb[p][7];
            mrg[p][5+BUTTONS] = bus.joy[16*p+5+BUTTONS] | kb[p][8];
        end
    end

    // Rotation, autofire gating and coin stretching into the output register.
    always_comb begin
        coin_prev_d = coin_prev_q;
        coin_cnt_d  = coin_cnt_q;
        out_d       = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            coin_prev_d[p] = mrg[p][5+BUTTONS];
            if (mrg[p][5+BUTTONS] && !coin_prev_q[p]) begin
                coin_cnt_d[p] = COIN_HOLD;
            end else if (coin_cnt_q[p] != 16'd0) begin
                coin_cnt_d[p] = coin_cnt_q[p] - 16'd1;
            end else begin
                coin_cnt_d[p] = 16'd0;
            end

            case (bus.rotate)
                2'd1: begin
                    out_d[W*p+0] = mrg[p][2];
                    out_d[W*p+1] = mrg[p][3];
                    out_d[W*p+2] = mrg[p][1];
                    out_d[W*p+3] = mrg[p][0];
                end
                2'd2: begin
                    out_d[W*p+0] = mrg[p][3];
                    out_d[W*p+1] = mrg[p][2];
                    out_d[W*p+2] = mrg[p][0];
                    out_d[W*p+3] = mrg[p][1];
                end
                default: begin
                    out_d[W*p+0] = mrg[p][0];
                    out_d[W*p+1] = mrg[p][1];
                    out_d[W*p+2] = mrg[p][2];
                    out_d[W*p+3] = mrg[p][3];
                end
            endcase

            out_d[W*p+4] = mrg[p][4] & (phase_q | ~bus.autofire_en[p]);
            for (int b = 1; b < BUTTONS; b++) begin
                out_d[W*p+4+b] = mrg[p][4+b];
            end
            out_d[W*p+4+BUTTONS] = mrg[p][4+BUTTONS];
            out_d[W*p+5+BUTTONS] = mrg[p][5+BUTTONS] | (coin_cnt_q[p] != 16'd0);
        end
    end

    // Free-running autofire divider; phase flips each time the count wraps.
    always_comb begin
        if (div_q >= AUTOFIRE_DIV - 20'd1) begin
            div_d   = 20'd0;
            phase_d = ~phase_q;
        end else begin
            div_d   = div_q + 20'd1;
            phase_d = phase_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed_q    <= 1'b0;
            tog_q       <= 1'b0;
            key_q       <= '0;
            coin_prev_q <= '0;
            coin_cnt_q  <= '0;
            div_q       <= 20'd0;
            phase_q     <= 1'b1;
            out_q       <= '0;
        end else begin
            primed_q    <= primed_d;
            tog_q       <= tog_d;
            key_q       <= key_d;
            coin_prev_q <= coin_prev_d;
            coin_cnt_q  <= coin_cnt_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            out_q       <= out_d;
        end
    end

    assign bus.player_out = out_q;
endmodule
